// File: rtl/spu_pkg.sv
// Shared widths, types and the write-back bypass select for the SPU register-fetch stage.
package spu_pkg;

  localparam int unsigned REG_ADDR_W = 7;
  localparam int unsigned REG_W      = 128;
  localparam int unsigned PIPE_DEPTH = 4;

  typedef logic [0:REG_ADDR_W-1] reg_addr_t;
  typedef logic [0:REG_W-1]      quad_t;

  // The odd pipe is tested last so that it has priority over the even pipe.
  function automatic quad_t fwd_select(
    input quad_t     rf_val,
    input reg_addr_t addr,
    input logic      we_even,
    input reg_addr_t addr_even,
    input quad_t     data_even,
    input logic      we_odd,
    input reg_addr_t addr_odd,
    input quad_t     data_odd
  );
    quad_t val;
    val = rf_val;
    if (we_even && (addr_even == addr)) val = data_even;
    if (we_odd && (addr_odd == addr))   val = data_odd;
    return val;
  endfunction

endpackage

// File: rtl/hazard_check.sv
// Compares one source address against the stalling delay taps of both pipes.
module hazard_check
  import spu_pkg::*;
#(
  parameter int unsigned DEPTH = PIPE_DEPTH
) (
  input  logic [0:REG_ADDR_W-1]              i_addr,
  input  logic                               i_used,
  input  logic [DEPTH-1:0][0:REG_ADDR_W-1]   i_addr_delay_even,
  input  logic [DEPTH-1:0][0:REG_ADDR_W-1]   i_addr_delay_odd,
  input  logic [DEPTH-1:0]                   i_write_delay_even,
  input  logic [DEPTH-1:0]                   i_write_delay_odd,
  output logic                               o_hazard
);

  // The last tap is the WB port itself, which the bypass covers.
  always_comb begin
    o_hazard = 1'b0;
    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
      if (i_write_delay_even[k] && (i_addr_delay_even[k] == i_addr)) o_hazard = i_used;
      if (i_write_delay_odd[k] && (i_addr_delay_odd[k] == i_addr))   o_hazard = i_used;
    end
  end

endmodule

// File: rtl/rf_fwd_stage.sv
// SPU register-fetch stage: 128-entry register file, WB bypass, RAW stall detection and
// registered operand delivery.
module rf_fwd_stage
  import spu_pkg::*;
#(
  parameter int unsigned NUM_REGS = 128,
  parameter int unsigned WIDTH    = REG_W,
  parameter int unsigned DEPTH    = PIPE_DEPTH
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_instr_valid,
  input  logic [0:REG_ADDR_W-1]              i_ra_addr,
  input  logic [0:REG_ADDR_W-1]              i_rb_addr,
  input  logic [0:REG_ADDR_W-1]              i_rc_addr,
  input  logic                               i_ra_used,
  input  logic                               i_rb_used,
  input  logic                               i_rc_used,
  input  logic [0:WIDTH-1]                   i_rt_wb_even,
  input  logic [0:WIDTH-1]                   i_rt_wb_odd,
  input  logic [0:REG_ADDR_W-1]              i_rt_addr_wb_even,
  input  logic [0:REG_ADDR_W-1]              i_rt_addr_wb_odd,
  input  logic                               i_reg_write_wb_even,
  input  logic                               i_reg_write_wb_odd,
  input  logic [DEPTH-1:0][0:REG_ADDR_W-1]   i_rt_addr_delay_even,
  input  logic [DEPTH-1:0][0:REG_ADDR_W-1]   i_rt_addr_delay_odd,
  input  logic [DEPTH-1:0]                   i_reg_write_delay_even,
  input  logic [DEPTH-1:0]                   i_reg_write_delay_odd,
  output logic [0:WIDTH-1]                   o_ra,
  output logic [0:WIDTH-1]                   o_rb,
  output logic [0:WIDTH-1]                   o_rc,
  output logic                               o_operand_valid,
  output logic                               o_stall,
  output logic                               o_wb_conflict,
  output logic [31:0]                        o_stall_count
);

  logic [0:WIDTH-1] r_rf [NUM_REGS];
  logic [0:WIDTH-1] r_ra, r_rb, r_rc;
  logic             r_operand_valid;
  logic             r_wb_conflict;
  logic [31:0]      r_stall_count;

  logic             w_haz_ra, w_haz_rb, w_haz_rc;
  logic [0:WIDTH-1] w_ra_fwd, w_rb_fwd, w_rc_fwd;
  logic             w_issue;
  logic             w_conflict;

  hazard_check #(.DEPTH(DEPTH)) u_haz_ra (
    .i_addr             (i_ra_addr),
    .i_used             (i_ra_used),
    .i_addr_delay_even  (i_rt_addr_delay_even),
    .i_addr_delay_odd   (i_rt_addr_delay_odd),
    .i_write_delay_even (i_reg_write_delay_even),
    .i_write_delay_odd  (i_reg_write_delay_odd),
    .o_hazard           (w_haz_ra)
  );

  hazard_check #(.DEPTH(DEPTH)) u_haz_rb (
    .i_addr             (i_rb_addr),
    .i_used             (i_rb_used),
    .i_addr_delay_even  (i_rt_addr_delay_even),
    .i_addr_delay_odd   (i_rt_addr_delay_odd),
    .i_write_delay_even (i_reg_write_delay_even),
    .i_write_delay_odd  (i_reg_write_delay_odd),
    .o_hazard           (w_haz_rb)
  );

  hazard_check #(.DEPTH(DEPTH)) u_haz_rc (
    .i_addr             (i_rc_addr),
    .i_used             (i_rc_used),
    .i_addr_delay_even  (i_rt_addr_delay_even),
    .i_addr_delay_odd   (i_rt_addr_delay_odd),
    .i_write_delay_even (i_reg_write_delay_even),
    .i_write_delay_odd  (i_reg_write_delay_odd),
    .o_hazard           (w_haz_rc)
  );

  assign o_stall    = i_instr_valid & ~i_reset & (w_haz_ra | w_haz_rb | w_haz_rc);
  assign w_issue    = i_instr_valid & ~o_stall;
  assign w_conflict = i_reg_write_wb_even & i_reg_write_wb_odd &
                      (i_rt_addr_wb_even == i_rt_addr_wb_odd);

  // Sources hitting a same-cycle WB take the WB data so the array is never read stale.
  assign w_ra_fwd = fwd_select(r_rf[i_ra_addr], i_ra_addr,
                               i_reg_write_wb_even, i_rt_addr_wb_even, i_rt_wb_even,
                               i_reg_write_wb_odd, i_rt_addr_wb_odd, i_rt_wb_odd);
  assign w_rb_fwd = fwd_select(r_rf[i_rb_addr], i_rb_addr,
                               i_reg_write_wb_even, i_rt_addr_wb_even, i_rt_wb_even,
                               i_reg_write_wb_odd, i_rt_addr_wb_odd, i_rt_wb_odd);
  assign w_rc_fwd = fwd_select(r_rf[i_rc_addr], i_rc_addr,
                               i_reg_write_wb_even, i_rt_addr_wb_even, i_rt_wb_even,
                               i_reg_write_wb_odd, i_rt_addr_wb_odd, i_rt_wb_odd);

  // Odd write is issued second so it wins on an address collision.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_rf[i] <= '0;
    end else begin
      if (i_reg_write_wb_even) r_rf[i_rt_addr_wb_even] <= i_rt_wb_even;
      if (i_reg_write_wb_odd)  r_rf[i_rt_addr_wb_odd]  <= i_rt_wb_odd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ra            <= '0;
      r_rb            <= '0;
      r_rc            <= '0;
      r_operand_valid <= 1'b0;
      r_wb_conflict   <= 1'b0;
      r_stall_count   <= '0;
    end else begin
      r_operand_valid <= w_issue;
      r_wb_conflict   <= w_conflict;
      if (w_issue) begin
        r_ra <= w_ra_fwd;
        r_rb <= w_rb_fwd;
        r_rc <= w_rc_fwd;
      end
      if (o_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign o_ra            = r_ra;
  assign o_rb            = r_rb;
  assign o_rc            = r_rc;
  assign o_operand_valid = r_operand_valid;
  assign o_wb_conflict   = r_wb_conflict;
  assign o_stall_count   = r_stall_count;

endmodule

// File: tb/tb_rf_fwd_stage.sv
// Directed bench for rf_fwd_stage: reset, read, bypass, RAW stall/release, conflict, mid-stall reset.
module tb_rf_fwd_stage;

  logic             clk = 1'b0;
  logic             reset;
  logic             instr_valid;
  logic [0:6]       ra_addr, rb_addr, rc_addr;
  logic             ra_used, rb_used, rc_used;
  logic [0:127]     wb_even, wb_odd;
  logic [0:6]       addr_wb_even, addr_wb_odd;
  logic             we_wb_even, we_wb_odd;
  logic [3:0][0:6]  tap_even, tap_odd;
  logic [3:0]       tap_we_even, tap_we_odd;
  logic [0:127]     ra, rb, rc;
  logic             operand_valid, stall, wb_conflict;
  logic [31:0]      stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] ValA  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] ValAA = {16{8'hAA}};
  localparam logic [127:0] Val55 = {16{8'h55}};

  always #5 clk = ~clk;

  rf_fwd_stage dut (
    .i_clk                  (clk),
    .i_reset                (reset),
    .i_instr_valid          (instr_valid),
    .i_ra_addr              (ra_addr),
    .i_rb_addr              (rb_addr),
    .i_rc_addr              (rc_addr),
    .i_ra_used              (ra_used),
    .i_rb_used              (rb_used),
    .i_rc_used              (rc_used),
    .i_rt_wb_even           (wb_even),
    .i_rt_wb_odd            (wb_odd),
    .i_rt_addr_wb_even      (addr_wb_even),
    .i_rt_addr_wb_odd       (addr_wb_odd),
    .i_reg_write_wb_even    (we_wb_even),
    .i_reg_write_wb_odd     (we_wb_odd),
    .i_rt_addr_delay_even   (tap_even),
    .i_rt_addr_delay_odd    (tap_odd),
    .i_reg_write_delay_even (tap_we_even),
    .i_reg_write_delay_odd  (tap_we_odd),
    .o_ra                   (ra),
    .o_rb                   (rb),
    .o_rc                   (rc),
    .o_operand_valid        (operand_valid),
    .o_stall                (stall),
    .o_wb_conflict          (wb_conflict),
    .o_stall_count          (stall_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid = 1'b0;
    ra_addr = '0; rb_addr = '0; rc_addr = '0;
    ra_used = 1'b1; rb_used = 1'b1; rc_used = 1'b1;
    wb_even = '0; wb_odd = '0; addr_wb_even = '0; addr_wb_odd = '0;
    we_wb_even = 1'b0; we_wb_odd = 1'b0;
    tap_even = '0; tap_odd = '0; tap_we_even = '0; tap_we_odd = '0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    // Hazard presented during reset must not stall.
    instr_valid = 1'b1; ra_addr = 7'd7; tap_odd[0] = 7'd7; tap_we_odd[0] = 1'b1;
    #1;
    check("stall_in_reset", {127'd0, stall}, 128'd0);
    tick();
    check("rst_ra", ra, 128'd0);
    check("rst_ov", {127'd0, operand_valid}, 128'd0);
    check("rst_conflict", {127'd0, wb_conflict}, 128'd0);
    check("rst_stall_count", {96'd0, stall_count}, 128'd0);

    // Reset then read.
    clear_inputs();
    reset = 1'b0;
    instr_valid = 1'b1; ra_addr = 7'd5;
    tick();
    check("read5_ra", ra, 128'd0);
    check("read5_ov", {127'd0, operand_valid}, 128'd1);

    // Write through odd WB, no instruction.
    clear_inputs();
    we_wb_odd = 1'b1; addr_wb_odd = 7'd10; wb_odd = ValA;
    tick();
    check("idle_ov", {127'd0, operand_valid}, 128'd0);
    check("idle_ra_hold", ra, 128'd0);
    clear_inputs();
    instr_valid = 1'b1; ra_addr = 7'd10;
    tick();
    check("read10_ra", ra, ValA);

    // Same-cycle even bypass on rb.
    clear_inputs();
    we_wb_even = 1'b1; addr_wb_even = 7'd3; wb_even = ValAA;
    instr_valid = 1'b1; ra_addr = 7'd10; rb_addr = 7'd3;
    tick();
    check("bypass_rb", rb, ValAA);
    check("bypass_ra", ra, ValA);

    // RAW stall: reg 7 walks down the odd taps.
    clear_inputs();
    instr_valid = 1'b1; ra_addr = 7'd7;
    tap_odd[0] = 7'd7; tap_we_odd[0] = 1'b1;
    #1;
    check("stall_tap0", {127'd0, stall}, 128'd1);
    tick();
    tap_odd = '0; tap_we_odd = '0;
    tap_odd[1] = 7'd7; tap_we_odd[1] = 1'b1;
    #1;
    check("stall_tap1", {127'd0, stall}, 128'd1);
    check("stall_ov", {127'd0, operand_valid}, 128'd0);
    check("stall_ra_hold", ra, ValA);
    tick();
    tap_odd = '0; tap_we_odd = '0;
    tap_odd[2] = 7'd7; tap_we_odd[2] = 1'b1;
    #1;
    check("stall_tap2", {127'd0, stall}, 128'd1);
    tick();
    tap_odd = '0; tap_we_odd = '0;
    tap_odd[3] = 7'd7; tap_we_odd[3] = 1'b1;
    we_wb_odd = 1'b1; addr_wb_odd = 7'd7; wb_odd = Val55;
    #1;
    check("release_tap3", {127'd0, stall}, 128'd0);
    tick();
    check("release_ra", ra, Val55);
    check("release_ov", {127'd0, operand_valid}, 128'd1);
    check("stall_count3", {96'd0, stall_count}, 128'd3);

    // Unused source with a pending hazard.
    clear_inputs();
    instr_valid = 1'b1; ra_addr = 7'd7; ra_used = 1'b0;
    tap_odd[0] = 7'd7; tap_we_odd[0] = 1'b1;
    #1;
    check("unused_stall", {127'd0, stall}, 128'd0);
    tick();
    check("unused_ov", {127'd0, operand_valid}, 128'd1);
    check("unused_ra", ra, Val55);
    check("unused_count", {96'd0, stall_count}, 128'd3);

    // Even-pipe hazard on rb at the last stalling tap, then at the WB tap.
    clear_inputs();
    instr_valid = 1'b1; rb_addr = 7'd9;
    tap_even[2] = 7'd9; tap_we_even[2] = 1'b1;
    #1;
    check("even_tap2_stall", {127'd0, stall}, 128'd1);
    tap_even = '0; tap_we_even = '0;
    tap_even[3] = 7'd9; tap_we_even[3] = 1'b1;
    #1;
    check("even_tap3_nostall", {127'd0, stall}, 128'd0);
    tick();
    check("even_count", {96'd0, stall_count}, 128'd3);

    // Write conflict on reg 20 with same-cycle read: odd wins.
    clear_inputs();
    we_wb_even = 1'b1; addr_wb_even = 7'd20; wb_even = 128'd1;
    we_wb_odd  = 1'b1; addr_wb_odd  = 7'd20; wb_odd  = 128'd2;
    instr_valid = 1'b1; ra_addr = 7'd20;
    tick();
    check("conflict_pulse", {127'd0, wb_conflict}, 128'd1);
    check("conflict_bypass", ra, 128'd2);
    clear_inputs();
    instr_valid = 1'b1; ra_addr = 7'd20;
    tick();
    check("conflict_drop", {127'd0, wb_conflict}, 128'd0);
    check("conflict_read", ra, 128'd2);

    // Reset in the middle of a stall.
    clear_inputs();
    instr_valid = 1'b1; rc_addr = 7'd30;
    tap_even[1] = 7'd30; tap_we_even[1] = 1'b1;
    #1;
    check("pre_reset_stall", {127'd0, stall}, 128'd1);
    reset = 1'b1;
    #1;
    check("reset_drops_stall", {127'd0, stall}, 128'd0);
    tick();
    check("reset_count", {96'd0, stall_count}, 128'd0);
    check("reset_ra", ra, 128'd0);
    reset = 1'b0;
    clear_inputs();
    instr_valid = 1'b1; ra_addr = 7'd7;
    tick();
    check("reset_clears_rf", ra, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
